// File: rtl/lab2_proc_imul_iter_unit.sv
// lab2_proc_imul_iter_unit
//   Iterative shift-and-add integer multiplier for the X stage. It computes
//   all four RV32M product modes on magnitudes, then restores the sign at the
//   end. It retires p_bits_per_cycle multiplier bits per CALC cycle.
//
// Parameters
//   p_nbits           operand/result width
//   p_bits_per_cycle  multiplier bits consumed per CALC cycle (1, 2 or 4; divides p_nbits)
//
// Ports
//   clk, reset        clock; asynchronous active-high reset
//   req_val/req_rdy   request handshake (req_rdy high only in IDLE)
//   req_fn            00 mul (low), 01 mulh s*s, 10 mulhsu s*u, 11 mulhu u*u
//   req_a, req_b      operands (rs1, rs2)
//   resp_val/resp_rdy response handshake (resp_val high only in DONE)
//   resp_msg          selected half of the 2*p_nbits product, held while in DONE
//
// Optional feature
//   LAB2_PROC_IMUL_EARLY_EXIT_EN: when defined, CALC ends as soon as the
//   remaining multiplier bits are all zero. The result is unchanged; only the
//   latency becomes data dependent.

module lab2_proc_imul_iter_unit #(
    parameter int p_nbits          = 32,
    parameter int p_bits_per_cycle = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_val,
    output logic               req_rdy,
    input  logic [1:0]         req_fn,
    input  logic [p_nbits-1:0] req_a,
    input  logic [p_nbits-1:0] req_b,
    output logic               resp_val,
    input  logic               resp_rdy,
    output logic [p_nbits-1:0] resp_msg
);

    localparam int C_NCYC = p_nbits / p_bits_per_cycle;
    localparam int C_CW   = $clog2(C_NCYC + 1);
    localparam int C_W2   = 2 * p_nbits;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state_reg, state_next;
    logic [C_CW-1:0]    cnt_reg;
    logic [C_W2-1:0]    acc_reg;
    logic [C_W2-1:0]    a_reg;      // |a|, shifted left each CALC cycle
    logic [p_nbits-1:0] b_reg;      // |b|, shifted right each CALC cycle
    logic               neg_reg;
    logic [1:0]         fn_reg;
    logic [p_nbits-1:0] msg_reg;

    // Operand magnitudes at request time
    logic               a_neg, b_neg;
    logic [p_nbits-1:0] a_mag, b_mag;

    assign a_neg = ((req_fn == 2'b01) || (req_fn == 2'b10)) && req_a[p_nbits-1];
    assign b_neg = (req_fn == 2'b01) && req_b[p_nbits-1];
    // Negating the most-negative value yields the same bit pattern, which is
    // exactly its magnitude when read as unsigned.
    assign a_mag = a_neg ? -req_a : req_a;
    assign b_mag = b_neg ? -req_b : req_b;

    // One shifted copy of |a| per multiplier bit retired this cycle
    logic [C_W2-1:0] pp_term [p_bits_per_cycle];

    generate
        for (genvar gi = 0; gi < p_bits_per_cycle; gi++) begin : g_pp
            assign pp_term[gi] = b_reg[gi] ? (a_reg << gi) : '0;
        end
    endgenerate

    logic [C_W2-1:0]    partial;
    logic [C_W2-1:0]    acc_sum;
    logic [C_W2-1:0]    product;
    logic [p_nbits-1:0] b_shift;
    logic [p_nbits-1:0] result;
    logic               calc_last;

    always_comb begin
        partial = '0;
        for (int i = 0; i < p_bits_per_cycle; i++) begin
            partial = partial + pp_term[i];
        end
        acc_sum = acc_reg + partial;
        b_shift = b_reg >> p_bits_per_cycle;
        product = neg_reg ? -acc_sum : acc_sum;
        result  = (fn_reg == 2'b00) ? product[p_nbits-1:0] : product[C_W2-1:p_nbits];
`ifdef LAB2_PROC_IMUL_EARLY_EXIT_EN
        calc_last = (cnt_reg == C_CW'(C_NCYC - 1)) || (b_shift == '0);
`else
        calc_last = (cnt_reg == C_CW'(C_NCYC - 1));
`endif
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req_val)   state_next = CALC;
            CALC:    if (calc_last) state_next = DONE;
            DONE:    if (resp_rdy)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
            acc_reg <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            neg_reg <= 1'b0;
            fn_reg  <= 2'b00;
            msg_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_val) begin
                        a_reg   <= {{p_nbits{1'b0}}, a_mag};
                        b_reg   <= b_mag;
                        neg_reg <= a_neg ^ b_neg;
                        fn_reg  <= req_fn;
                        acc_reg <= '0;
                        cnt_reg <= '0;
                    end
                end
                CALC: begin
                    acc_reg <= acc_sum;
                    a_reg   <= a_reg << p_bits_per_cycle;
                    b_reg   <= b_shift;
                    cnt_reg <= cnt_reg + C_CW'(1);
                    // The result is captured once on entry to DONE and then
                    // held for as long as the consumer stalls.
                    if (calc_last) begin
                        msg_reg <= result;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_rdy  = (state_reg == IDLE);
    assign resp_val = (state_reg == DONE);
    assign resp_msg = msg_reg;

endmodule

// File: tb/tb_lab2_proc_imul_iter_unit.sv
// Testbench for lab2_proc_imul_iter_unit.
// dut0 uses the default configuration (32 bits, 1 bit per cycle).
// dut1 retires 4 bits per cycle.
// Expected products come from plain 64-bit arithmetic on sign- or zero-extended
// operands. Expected latencies come from the number of multiplier bits.

module tb_lab2_proc_imul_iter_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req_fn = 2'b00;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        req_val0 = 1'b0, req_val1 = 1'b0;
    logic        resp_rdy0 = 1'b0, resp_rdy1 = 1'b0;
    logic        req_rdy0, req_rdy1, resp_val0, resp_val1;
    logic [31:0] resp_msg0, resp_msg1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    lab2_proc_imul_iter_unit #(.p_nbits(32), .p_bits_per_cycle(1)) dut0 (
        .clk      (clk),
        .reset    (reset),
        .req_val  (req_val0),
        .req_rdy  (req_rdy0),
        .req_fn   (req_fn),
        .req_a    (req_a),
        .req_b    (req_b),
        .resp_val (resp_val0),
        .resp_rdy (resp_rdy0),
        .resp_msg (resp_msg0)
    );

    lab2_proc_imul_iter_unit #(.p_nbits(32), .p_bits_per_cycle(4)) dut1 (
        .clk      (clk),
        .reset    (reset),
        .req_val  (req_val1),
        .req_rdy  (req_rdy1),
        .req_fn   (req_fn),
        .req_a    (req_a),
        .req_b    (req_b),
        .resp_val (resp_val1),
        .resp_rdy (resp_rdy1),
        .resp_msg (resp_msg1)
    );

    // Reference product: extend each operand to 64 bits according to its
    // signedness, multiply modulo 2^64, then pick a half.
    function automatic logic [31:0] model(input logic [1:0] fn, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = (fn == 2'b01 || fn == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
        eb = (fn == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
        p  = ea * eb;
        return (fn == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // Cycles from the accepting edge until resp_val is first seen.
    function automatic int lat_of(input int which, input logic [1:0] fn, input logic [31:0] b);
        int k;
        k = (which == 0) ? 1 : 4;
`ifdef LAB2_PROC_IMUL_EARLY_EXIT_EN
        begin
            logic [31:0] m;
            int n;
            m = (fn == 2'b01 && b[31]) ? -b : b;
            n = 0;
            do begin
                m = m >> k;
                n++;
            end while (m != 0);
            return n + 1;
        end
`else
        return 32 / k + 1;
`endif
    endfunction

    function automatic logic rdy_of(input int which);
        return (which == 0) ? req_rdy0 : req_rdy1;
    endfunction

    function automatic logic val_of(input int which);
        return (which == 0) ? resp_val0 : resp_val1;
    endfunction

    function automatic logic [31:0] msg_of(input int which);
        return (which == 0) ? resp_msg0 : resp_msg1;
    endfunction

    task automatic set_req_val(input int which, input logic v);
        if (which == 0) req_val0 = v;
        else            req_val1 = v;
    endtask

    task automatic set_resp_rdy(input int which, input logic v);
        if (which == 0) resp_rdy0 = v;
        else            resp_rdy1 = v;
    endtask

    task automatic start_op(input int which, input logic [1:0] fn, input logic [31:0] a,
                            input logic [31:0] b, input string tag);
        chk({tag, "/req_rdy"}, rdy_of(which), 1'b1);
        req_fn = fn;
        req_a  = a;
        req_b  = b;
        set_req_val(which, 1'b1);
    endtask

    // req_val must already be high; the next edge accepts it.
    task automatic wait_resp(input int which, input int lat, input logic [31:0] exp,
                             input string tag);
        int cnt;
        logic got;
        cnt = 0;
        got = 1'b0;
        while (!got && cnt < 100) begin
            @(posedge clk);
            #1;
            cnt++;
            if (cnt == 1) set_req_val(which, 1'b0);
            got = val_of(which);
        end
        chk({tag, "/timeout"}, got, 1'b1);
        chk({tag, "/latency"}, cnt, lat);
        chk({tag, "/msg"}, msg_of(which), exp);
        $display("op %s dut%0d fn=%0d a=%h b=%h msg=%h exp=%h lat=%0d", tag, which,
                 req_fn, req_a, req_b, msg_of(which), exp, cnt);
    endtask

    task automatic handshake(input int which, input string tag);
        set_resp_rdy(which, 1'b1);
        @(posedge clk);
        #1;
        set_resp_rdy(which, 1'b0);
        chk({tag, "/b2b_rdy"}, rdy_of(which), 1'b1);
        chk({tag, "/b2b_val"}, val_of(which), 1'b0);
    endtask

    task automatic run_op(input int which, input logic [1:0] fn, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input string tag);
        start_op(which, fn, a, b, tag);
        wait_resp(which, lat_of(which, fn, b), exp, tag);
        handshake(which, tag);
    endtask

    initial begin
        logic [31:0] corners [5];
        logic [31:0] ra, rb, exp_a;
        logic [1:0]  rf;
        logic        seen_val;

        corners[0] = 32'h0000_0000;
        corners[1] = 32'h0000_0001;
        corners[2] = 32'h8000_0000;
        corners[3] = 32'hFFFF_FFFF;
        corners[4] = 32'h7FFF_FFFF;

        // Reset state while reset is held
        repeat (2) @(posedge clk);
        #1;
        chk("rst/req_rdy0", req_rdy0, 1'b1);
        chk("rst/resp_val0", resp_val0, 1'b0);
        chk("rst/resp_msg0", resp_msg0, 32'h0);
        chk("rst/req_rdy1", req_rdy1, 1'b1);
        chk("rst/resp_val1", resp_val1, 1'b0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst/req_rdy0", req_rdy0, 1'b1);
        chk("post_rst/resp_msg0", resp_msg0, 32'h0);

        // Directed products
        run_op(0, 2'b00, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7xm3");
        run_op(0, 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_min");
        run_op(0, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max");
        run_op(0, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1");
        run_op(0, 2'b00, 32'h0000_1234, 32'h0000_0001, 32'h0000_1234, "mul_b1");
        run_op(0, 2'b00, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, "mul_b0");
        run_op(1, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "k4_mulhu_max");
        run_op(1, 2'b01, 32'hFFFF_FFF9, 32'h0000_0003, 32'hFFFF_FFFF, "k4_mulh_neg");

        // Backpressure: DONE held 5 cycles with a second request pending
        start_op(0, 2'b00, 32'd1000, 32'd3000, "bp_a");
        wait_resp(0, lat_of(0, 2'b00, 32'd3000), 32'd3000000, "bp_a");
        req_fn = 2'b11;
        req_a  = 32'hDEAD_BEEF;
        req_b  = 32'h0000_0100;
        req_val0 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp/msg_stable", resp_msg0, 32'd3000000);
            chk("bp/req_rdy_low", req_rdy0, 1'b0);
            chk("bp/val_held", resp_val0, 1'b1);
        end
        handshake(0, "bp_a");
        wait_resp(0, lat_of(0, 2'b11, 32'h0000_0100), model(2'b11, 32'hDEAD_BEEF, 32'h100), "bp_b");
        handshake(0, "bp_b");

        // Reset during the 10th CALC cycle
        start_op(0, 2'b00, 32'hFFFF_0000, 32'hFFFF_FFFF, "rst_mid");
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) req_val0 = 1'b0;
        end
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid/resp_val", resp_val0, 1'b0);
        chk("rst_mid/req_rdy", req_rdy0, 1'b1);
        chk("rst_mid/resp_msg", resp_msg0, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        seen_val = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (resp_val0) seen_val = 1'b1;
        end
        chk("rst_mid/no_resp", seen_val, 1'b0);
        run_op(0, 2'b00, 32'd3, 32'd5, 32'h0000_000F, "after_rst_3x5");

        // Randomized operations on both configurations
        for (int i = 0; i < 16; i++) begin
            rf = 2'($urandom_range(0, 3));
            ra = ($urandom_range(0, 2) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
            case ($urandom_range(0, 3))
                0:       rb = corners[$urandom_range(0, 4)];
                1:       rb = 32'($urandom_range(0, 255));
                default: rb = $urandom;
            endcase
            exp_a = model(rf, ra, rb);
            run_op(i % 2, rf, ra, rb, exp_a, $sformatf("rand%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
